// File: rtl/sam_mem_arbiter.sv
// rtl/sam_mem_arbiter.sv - single-port RAM arbiter, SAM strobe port over PicoRV32 native port
//
// Owns the one synchronous RAM port. The SAM wrapper has no ready input, so
// its strobe always wins and gets a fixed read latency. CPU requests go
// through a three-state FSM (IDLE -> CPU_RESP -> CPU_ACK) and are deferred in
// any IDLE cycle where SAM strobes. Out-of-range accesses are flagged, never
// aliased into the RAM.
//
// Ports:
//   Clk, Rst            clock, asynchronous active-high reset
//   cpu_mem_*           PicoRV32 native memory interface (valid/ready handshake)
//   mem_*_SAM           SAM wrapper strobe port; mem_rdata_SAM holds last read
//   ram_*               synchronous RAM port, read data valid one cycle after ram_en
//   oor_cpu, oor_sam    sticky out-of-range flags
//   conflict_cnt        saturating count of CPU deferrals caused by SAM
module sam_mem_arbiter #(
  parameter int MEM_WORDS = 16384,
  parameter int AW        = 14
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          cpu_mem_valid,
  input  logic [31:0]   cpu_mem_addr,
  input  logic [31:0]   cpu_mem_wdata,
  input  logic [3:0]    cpu_mem_wstrb,
  output logic          cpu_mem_ready,
  output logic [31:0]   cpu_mem_rdata,
  input  logic          mem_en_SAM,
  input  logic [3:0]    mem_wstrb_SAM,
  input  logic [31:0]   mem_addr_SAM,
  input  logic [31:0]   mem_wdata_SAM,
  output logic [31:0]   mem_rdata_SAM,
  output logic          ram_en,
  output logic [3:0]    ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata,
  output logic          oor_cpu,
  output logic          oor_sam,
  output logic [15:0]   conflict_cnt
);

  typedef enum logic [1:0] {IDLE, CPU_RESP, CPU_ACK} state_t;

  localparam logic [31:0] WORD_LIMIT = 32'(MEM_WORDS);

  state_t state, state_nxt;

  logic [29:0] cpu_idx, sam_idx;
  logic        cpu_in_range, sam_in_range;
  logic        sam_hit, cpu_issue, cpu_hit, cpu_collide;
  logic        cpu_rd_ok;   // issued CPU access was an in-range read
  logic        sam_rd_pend; // SAM read issued last cycle
  logic        sam_rd_ok;   // ...and it was in range
  logic        unused_addr_lsbs;

  // Byte offset bits are irrelevant to a word-wide RAM.
  assign unused_addr_lsbs = ^{cpu_mem_addr[1:0], mem_addr_SAM[1:0]};

  assign cpu_idx      = cpu_mem_addr[31:2];
  assign sam_idx      = mem_addr_SAM[31:2];
  assign cpu_in_range = ({2'b00, cpu_idx} < WORD_LIMIT);
  assign sam_in_range = ({2'b00, sam_idx} < WORD_LIMIT);

  assign sam_hit     = mem_en_SAM & sam_in_range;
  // Any SAM strobe defers the CPU, even an out-of-range one: the decision
  // must not depend on SAM address decode so the CPU path stays simple.
  assign cpu_collide = (state == IDLE) & cpu_mem_valid & mem_en_SAM;
  assign cpu_issue   = (state == IDLE) & cpu_mem_valid & ~mem_en_SAM;
  assign cpu_hit     = cpu_issue & cpu_in_range;

  // RAM port mux: SAM first, CPU only in its issue cycle, otherwise all zero.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 4'b0000;
    ram_addr  = '0;
    ram_wdata = 32'h0;
    if (!Rst) begin
      if (sam_hit) begin
        ram_en    = 1'b1;
        ram_we    = mem_wstrb_SAM;
        ram_addr  = sam_idx[AW-1:0];
        ram_wdata = mem_wdata_SAM;
      end else if (cpu_hit) begin
        ram_en    = 1'b1;
        ram_we    = cpu_mem_wstrb;
        ram_addr  = cpu_idx[AW-1:0];
        ram_wdata = cpu_mem_wdata;
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (cpu_issue) state_nxt = CPU_RESP;
      CPU_RESP: state_nxt = CPU_ACK;
      CPU_ACK:  state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // CPU datapath: ram_rdata is valid during CPU_RESP, ready is seen in CPU_ACK.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      cpu_rd_ok     <= 1'b0;
      cpu_mem_ready <= 1'b0;
      cpu_mem_rdata <= 32'h0;
      oor_cpu       <= 1'b0;
      conflict_cnt  <= 16'h0000;
    end else begin
      if (cpu_issue) begin
        cpu_rd_ok <= cpu_in_range & (cpu_mem_wstrb == 4'b0000);
        if (!cpu_in_range) oor_cpu <= 1'b1;
      end
      if (state == CPU_RESP) begin
        cpu_mem_rdata <= cpu_rd_ok ? ram_rdata : 32'h0;
        cpu_mem_ready <= 1'b1;
      end else begin
        cpu_mem_ready <= 1'b0;
      end
      if (cpu_collide && conflict_cnt != 16'hFFFF)
        conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

  // SAM datapath: a read captures ram_rdata one cycle after the strobe;
  // out-of-range reads return zero, writes leave the held value alone.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      sam_rd_pend   <= 1'b0;
      sam_rd_ok     <= 1'b0;
      mem_rdata_SAM <= 32'h0;
      oor_sam       <= 1'b0;
    end else begin
      sam_rd_pend <= mem_en_SAM & (mem_wstrb_SAM == 4'b0000);
      sam_rd_ok   <= sam_in_range;
      if (sam_rd_pend)
        mem_rdata_SAM <= sam_rd_ok ? ram_rdata : 32'h0;
      if (mem_en_SAM && !sam_in_range)
        oor_sam <= 1'b1;
    end
  end

endmodule
